// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter and access sequencer for the external 1Mx16 SRAM.
// Shares the chip between the CPU port and an auxiliary (loader/DMA) port and
// generates registered active-low CE/UB/LB/OE/WE strobes, the SRAM address and
// the write-data enable for the board-level tristate bus.
//
// Optional feature macro: SRAM_ARB_RR_EN
//   defined   -> round-robin arbitration between simultaneous requests
//   undefined -> fixed priority, CPU over aux
//
// Request handshake: a requester raises req with we/addr/wdata and holds them
// until its ack pulses for one cycle. The fields are latched at grant, so a
// request that changes or drops mid-access still completes and is still acked.
// A req still high in the cycle after ack is taken as a new request.
//
// The FSM state is exported on state_o (0 = IDLE, 1 = ACCESS, 2 = DONE).

module sram_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2,   // OE/WE low time in cycles, 1..15
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DATA_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,       // asynchronous, active low

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,

    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              aux_ack,

    output logic              owner,

    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE,
    output logic [ADDR_W-1:0] ADDR,

    input  logic [DATA_W-1:0] Data_in,
    output logic [DATA_W-1:0] Data_out,
    output logic              Data_oe,

    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                lwe_q, lwe_d;        // latched write flag of access in flight
    logic                owner_q, owner_d;
    logic                ce_q, ce_d;
    logic                oe_q, oe_d;
    logic                we_q, we_d;
    logic                doe_q, doe_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   aux_rdata_q, aux_rdata_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                aux_ack_q, aux_ack_d;
    logic                grant_aux;

`ifdef SRAM_ARB_RR_EN
    logic                last_q, last_d;      // 1 = aux was granted last

    // Round-robin: on a tie, grant the port that was not granted last
    always_comb begin
        grant_aux = aux_req && (!cpu_req || !last_q);
    end

    // Last-granted register; resets to aux so the CPU wins the first tie
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) last_q <= 1'b1;
        else        last_q <= last_d;
    end

    // Remember who won whenever a grant is issued
    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && (cpu_req || aux_req)) last_d = grant_aux;
    end
`else
    // Fixed priority: aux only wins when the CPU is not asking
    always_comb begin
        grant_aux = aux_req && !cpu_req;
    end
`endif

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lwe_d       = lwe_q;
        owner_d     = owner_q;
        ce_d        = ce_q;
        oe_d        = oe_q;
        we_d        = we_q;
        doe_d       = doe_q;
        addr_d      = addr_q;
        dout_d      = dout_q;
        cpu_rdata_d = cpu_rdata_q;
        aux_rdata_d = aux_rdata_q;
        cpu_ack_d   = 1'b0;
        aux_ack_d   = 1'b0;

        case (state_q)
            IDLE: begin
                ce_d  = 1'b1;
                oe_d  = 1'b1;
                we_d  = 1'b1;
                doe_d = 1'b0;
                if (cpu_req || aux_req) begin
                    owner_d = grant_aux;
                    lwe_d   = grant_aux ? aux_we   : cpu_we;
                    addr_d  = grant_aux ? aux_addr : cpu_addr;
                    if (grant_aux ? aux_we : cpu_we)
                        dout_d = grant_aux ? aux_wdata : cpu_wdata;
                    cnt_d   = WAIT_LD;
                    state_d = ACCESS;
                    // Strobes for the first ACCESS cycle are set up here so
                    // they leave the flops together with the new address.
                    ce_d    = 1'b0;
                    oe_d    = grant_aux ? aux_we : cpu_we;
                    we_d    = grant_aux ? !aux_we : !cpu_we;
                    doe_d   = grant_aux ? aux_we : cpu_we;
                end
            end

            ACCESS: begin
                if (cnt_q <= 4'd1) begin
                    state_d = DONE;
                    ce_d    = 1'b1;
                    oe_d    = 1'b1;
                    we_d    = 1'b1;
                    doe_d   = lwe_q;          // hold write data one more cycle
                    if (!lwe_q) begin
                        if (owner_q) aux_rdata_d = Data_in;
                        else         cpu_rdata_d = Data_in;
                    end
                    cpu_ack_d = !owner_q;
                    aux_ack_d = owner_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
                doe_d   = 1'b0;
            end

            default: begin
                state_d = IDLE;
                ce_d    = 1'b1;
                oe_d    = 1'b1;
                we_d    = 1'b1;
                doe_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset forces all strobes inactive at once
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            lwe_q       <= 1'b0;
            owner_q     <= 1'b0;
            ce_q        <= 1'b1;
            oe_q        <= 1'b1;
            we_q        <= 1'b1;
            doe_q       <= 1'b0;
            addr_q      <= '0;
            dout_q      <= '0;
            cpu_rdata_q <= '0;
            aux_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            aux_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lwe_q       <= lwe_d;
            owner_q     <= owner_d;
            ce_q        <= ce_d;
            oe_q        <= oe_d;
            we_q        <= we_d;
            doe_q       <= doe_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            cpu_rdata_q <= cpu_rdata_d;
            aux_rdata_q <= aux_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            aux_ack_q   <= aux_ack_d;
        end
    end

    // Accesses are always full-width, so byte lanes follow chip enable
    always_comb begin
        CE        = ce_q;
        UB        = ce_q;
        LB        = ce_q;
        OE        = oe_q;
        WE        = we_q;
        ADDR      = addr_q;
        Data_out  = dout_q;
        Data_oe   = doe_q;
        owner     = owner_q;
        cpu_rdata = cpu_rdata_q;
        aux_rdata = aux_rdata_q;
        cpu_ack   = cpu_ack_q;
        aux_ack   = aux_ack_q;
        state_o   = state_q;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed self-checking bench for sram_arbiter (WAIT_CYCLES = 2).
// Outputs are sampled 1 time unit after the rising edge; inputs are driven there too.

module tb_sram_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;

    logic          Clk;
    logic          Reset;
    logic          cpu_req, cpu_we, aux_req, aux_we;
    logic [AW-1:0] cpu_addr, aux_addr;
    logic [DW-1:0] cpu_wdata, aux_wdata, cpu_rdata, aux_rdata;
    logic          cpu_ack, aux_ack, owner;
    logic          CE, UB, LB, OE, WE, Data_oe;
    logic [AW-1:0] ADDR;
    logic [DW-1:0] Data_in, Data_out;
    logic [1:0]    state_o;

    int tests;
    int fails;

    sram_arbiter #(.WAIT_CYCLES(2), .ADDR_W(AW), .DATA_W(DW)) dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
        .aux_wdata(aux_wdata), .aux_rdata(aux_rdata), .aux_ack(aux_ack),
        .owner(owner),
        .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .ADDR(ADDR),
        .Data_in(Data_in), .Data_out(Data_out), .Data_oe(Data_oe),
        .state_o(state_o)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        aux_req = 0; aux_we = 0; aux_addr = '0; aux_wdata = '0;
        Data_in = '0;
        tick(); tick();
        tests++;
        if ({CE, UB, LB, OE, WE} !== 5'b11111) begin
            fails++; $display("FAIL reset_strobes: got %b expected 11111", {CE, UB, LB, OE, WE});
        end
        tests++;
        if (ADDR !== '0 || Data_out !== '0 || Data_oe !== 1'b0) begin
            fails++; $display("FAIL reset_bus: got addr=%h dout=%h doe=%b expected 0/0/0", ADDR, Data_out, Data_oe);
        end
        tests++;
        if ({cpu_ack, aux_ack, owner} !== 3'b000 || cpu_rdata !== '0 || aux_rdata !== '0 || state_o !== 2'd0) begin
            fails++; $display("FAIL reset_ctrl: got acks=%b%b owner=%b rd=%h/%h st=%0d expected all 0",
                              cpu_ack, aux_ack, owner, cpu_rdata, aux_rdata, state_o);
        end
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_cpu_read();
        cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00123;
        tick();                               // cycle 1: ACCESS
        Data_in = 16'hBEEF;
        tests++;
        if (OE !== 1'b0 || WE !== 1'b1 || CE !== 1'b0 || ADDR !== 20'h00123 || Data_oe !== 1'b0) begin
            fails++; $display("FAIL rd_c1: got oe=%b we=%b ce=%b addr=%h doe=%b expected 0 1 0 00123 0",
                              OE, WE, CE, ADDR, Data_oe);
        end
        tick();                               // cycle 2: ACCESS
        tests++;
        if (OE !== 1'b0 || UB !== 1'b0 || LB !== 1'b0 || ADDR !== 20'h00123 || cpu_ack !== 1'b0) begin
            fails++; $display("FAIL rd_c2: got oe=%b ub=%b lb=%b addr=%h ack=%b expected 0 0 0 00123 0",
                              OE, UB, LB, ADDR, cpu_ack);
        end
        tick();                               // cycle 3: DONE
        cpu_req = 0;
        tests++;
        if (cpu_ack !== 1'b1 || aux_ack !== 1'b0 || cpu_rdata !== 16'hBEEF || OE !== 1'b1 || CE !== 1'b1) begin
            fails++; $display("FAIL rd_done: got ack=%b aux_ack=%b rdata=%h oe=%b ce=%b expected 1 0 beef 1 1",
                              cpu_ack, aux_ack, cpu_rdata, OE, CE);
        end
        tests++;
        if (ADDR !== 20'h00123 || owner !== 1'b0) begin
            fails++; $display("FAIL rd_addr_hold: got addr=%h owner=%b expected 00123 0", ADDR, owner);
        end
        tick();                               // cycle 4: IDLE
        Data_in = 16'h0000;
        tests++;
        if (cpu_ack !== 1'b0 || cpu_rdata !== 16'hBEEF || state_o !== 2'd0) begin
            fails++; $display("FAIL rd_after: got ack=%b rdata=%h st=%0d expected 0 beef 0", cpu_ack, cpu_rdata, state_o);
        end
    endtask

    task automatic test_aux_write();
        aux_req = 1; aux_we = 1; aux_addr = 20'h0FFFF; aux_wdata = 16'h1234;
        for (int c = 1; c <= 2; c++) begin
            tick();
            tests++;
            if (WE !== 1'b0 || OE !== 1'b1 || CE !== 1'b0 || Data_oe !== 1'b1 ||
                Data_out !== 16'h1234 || ADDR !== 20'h0FFFF || aux_ack !== 1'b0) begin
                fails++; $display("FAIL wr_c%0d: got we=%b oe=%b ce=%b doe=%b dout=%h addr=%h ack=%b expected 0 1 0 1 1234 0ffff 0",
                                  c, WE, OE, CE, Data_oe, Data_out, ADDR, aux_ack);
            end
        end
        tick();                               // DONE
        aux_req = 0;
        tests++;
        if (WE !== 1'b1 || OE !== 1'b1 || Data_oe !== 1'b1 || aux_ack !== 1'b1 || cpu_ack !== 1'b0 || owner !== 1'b1) begin
            fails++; $display("FAIL wr_done: got we=%b oe=%b doe=%b aux_ack=%b cpu_ack=%b owner=%b expected 1 1 1 1 0 1",
                              WE, OE, Data_oe, aux_ack, cpu_ack, owner);
        end
        tick();                               // IDLE
        tests++;
        if (Data_oe !== 1'b0 || aux_ack !== 1'b0 || aux_rdata !== '0) begin
            fails++; $display("FAIL wr_after: got doe=%b ack=%b aux_rdata=%h expected 0 0 0000", Data_oe, aux_ack, aux_rdata);
        end
    endtask

    task automatic test_simultaneous();
        logic exp_owner [4];
        int   exp_aux_acks;
        int   n;
        int   aux_acks;
        int   last_cyc;
`ifdef SRAM_ARB_RR_EN
        exp_owner[0] = 0; exp_owner[1] = 1; exp_owner[2] = 0; exp_owner[3] = 1;
        exp_aux_acks = 2;
`else
        exp_owner[0] = 0; exp_owner[1] = 0; exp_owner[2] = 0; exp_owner[3] = 0;
        exp_aux_acks = 0;
`endif
        n = 0; aux_acks = 0; last_cyc = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00010;
        aux_req = 1; aux_we = 0; aux_addr = 20'h00020;
        Data_in = 16'h5A5A;
        for (int cyc = 1; cyc <= 24 && n < 4; cyc++) begin
            tick();
            if (aux_ack) aux_acks++;
            if (cpu_ack || aux_ack) begin
                tests++;
                if (owner !== exp_owner[n] || aux_ack !== exp_owner[n] || cpu_ack === aux_ack) begin
                    fails++; $display("FAIL sim_grant%0d: got owner=%b cpu_ack=%b aux_ack=%b expected owner=%b",
                                      n, owner, cpu_ack, aux_ack, exp_owner[n]);
                end
                tests++;
                if (cyc - last_cyc !== ((n == 0) ? 3 : 4)) begin
                    fails++; $display("FAIL sim_spacing%0d: got %0d cycles expected %0d",
                                      n, cyc - last_cyc, (n == 0) ? 3 : 4);
                end
                last_cyc = cyc;
                n++;
                if (n == 4) begin
                    cpu_req = 0; aux_req = 0;
                end
            end
        end
        tests++;
        if (n !== 4) begin
            fails++; $display("FAIL sim_count: got %0d acks expected 4 (timeout)", n);
        end
        tests++;
        if (aux_acks !== exp_aux_acks) begin
            fails++; $display("FAIL sim_aux_acks: got %0d expected %0d", aux_acks, exp_aux_acks);
        end
        cpu_req = 0; aux_req = 0;
        tick(); tick();
        tests++;
        if (state_o !== 2'd0 || cpu_rdata !== 16'h5A5A) begin
            fails++; $display("FAIL sim_idle: got st=%0d rdata=%h expected 0 5a5a", state_o, cpu_rdata);
        end
    endtask

    task automatic test_reset_mid_access();
        int acks;
        acks = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 20'h00444; cpu_wdata = 16'hCAFE;
        tick();                               // ACCESS 1
        tick();                               // ACCESS 2
        Reset = 1'b0;
        #1;
        tests++;
        if (WE !== 1'b1 || CE !== 1'b1 || Data_oe !== 1'b0) begin
            fails++; $display("FAIL rst_mid: got we=%b ce=%b doe=%b expected 1 1 0", WE, CE, Data_oe);
        end
        cpu_req = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (cpu_ack || aux_ack) acks++;
        end
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (cpu_ack || aux_ack) acks++;
        end
        tests++;
        if (acks !== 0) begin
            fails++; $display("FAIL rst_no_ack: got %0d acks expected 0", acks);
        end
        cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00055; Data_in = 16'hA5A5;
        tick(); tick(); tick();               // ACCESS, ACCESS, DONE
        cpu_req = 0;
        tests++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 16'hA5A5) begin
            fails++; $display("FAIL rst_recover: got ack=%b rdata=%h expected 1 a5a5", cpu_ack, cpu_rdata);
        end
        tick();
    endtask

    task automatic test_early_drop();
        cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00200; Data_in = 16'h7777;
        tick();                               // ACCESS 1
        cpu_req = 0; cpu_addr = 20'h00300;
        tick();                               // ACCESS 2
        tests++;
        if (ADDR !== 20'h00200 || OE !== 1'b0) begin
            fails++; $display("FAIL drop_addr: got addr=%h oe=%b expected 00200 0", ADDR, OE);
        end
        tick();                               // DONE
        tests++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 16'h7777 || ADDR !== 20'h00200) begin
            fails++; $display("FAIL drop_ack: got ack=%b rdata=%h addr=%h expected 1 7777 00200", cpu_ack, cpu_rdata, ADDR);
        end
        tick(); tick();
        tests++;
        if (state_o !== 2'd0 || cpu_ack !== 1'b0 || OE !== 1'b1) begin
            fails++; $display("FAIL drop_idle: got st=%0d ack=%b oe=%b expected 0 0 1", state_o, cpu_ack, OE);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_cpu_read();
        test_aux_write();
        test_simultaneous();
        test_reset_mid_access();
        test_early_drop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and access sequencer for the external 1Mx16 SRAM. It shares the chip between the CPU memory port and an auxiliary requester (debug loader / DMA) and generates the active-low CE/UB/LB/OE/WE strobes and the address. It also drives the write-data enable for the board-level tristate data bus. It sits between the memory subsystem and the tristate buffer in the SLC-3 top level.

## Interface
Parameters:
- WAIT_CYCLES, 2, cycles the OE or WE strobe is held low per access; legal range 1..15
- ADDR_W, 20, SRAM address width
- DATA_W, 16, SRAM data width

Ports:
- Clk  in  1  system clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  read data, valid in the cpu_ack cycle and held until the next CPU read completes
- cpu_ack  out  1  one-cycle completion pulse
- aux_req, aux_we, aux_addr, aux_wdata, aux_rdata, aux_ack: same widths and semantics for the auxiliary port
- owner  out  1  port owning the current or last access; 0 = CPU, 1 = aux
- CE, UB, LB, OE, WE  out  1 each  active-low SRAM strobes
- ADDR  out  ADDR_W  SRAM address
- Data_in  in  DATA_W  data from the tristate buffer
- Data_out  out  DATA_W  write data to the tristate buffer
- Data_oe  out  1  1 = drive Data_out onto the bus

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE
  - All strobes high; Data_oe = 0.
  - If any req is high: grant one port and latch its we, addr and wdata into internal registers.
  - Load the wait counter with WAIT_CYCLES and go to ACCESS.
- ACCESS
  - CE, UB and LB are low.
  - ADDR shows the latched address.
  - Read: OE is low. Write: WE is low and Data_oe is 1.
  - Counter decrements each cycle.
  - On the last ACCESS cycle (counter = 1), a read captures Data_in into the owner's rdata register.
  - Then go to DONE.
- DONE
  - All strobes return high.
  - For writes, Data_oe stays 1 for this cycle as data hold time.
  - The owner's ack pulses for exactly one cycle.
  - Next state is IDLE.
- Arbitration (default): fixed priority. If cpu_req and aux_req are both high in IDLE, the CPU wins.
- Accesses are always full 16-bit: UB and LB track CE.
- Requester contract: req, we, addr and wdata stay stable from assertion until ack; req may be deasserted in the cycle after ack.
  - The arbiter latches the request fields, so a violation does not corrupt the access in flight.
  - A req dropped mid-access still completes and is still acked.
- A req still high in the cycle after ack is treated as a new request.

## Timing
- Reset values:
  - CE, UB, LB, OE, WE = 1; ADDR = 0; Data_out = 0; Data_oe = 0.
  - cpu_ack = aux_ack = 0; cpu_rdata = aux_rdata = 0; owner = 0; state = IDLE.
- Reset asserted mid-access: strobes go high and Data_oe goes low immediately (asynchronously). No ack is issued and the access is abandoned.
- Latency: req sampled high in IDLE at edge 0 gives ACCESS for edges 1..WAIT_CYCLES and ack high in cycle WAIT_CYCLES+1. Default is 3 cycles request-to-ack.
- Back-to-back throughput: one access per WAIT_CYCLES+2 cycles.
- All outputs are registered; there is no combinational path from any req to any SRAM strobe.
- ADDR changes only on entry to ACCESS, so it is stable before and after the OE/WE low window.

## Configuration
- SRAM_ARB_RR_EN
  - Defined: round-robin arbitration. A one-bit last-granted register (reset to aux, so the CPU wins first) gives simultaneous requests to the port not granted last. A lone request is always granted.
  - Undefined: fixed CPU-over-aux priority; the last-granted register is not built.

## Test plan
- Single CPU read:
  - Stimulus: WAIT_CYCLES = 2, cpu_addr = 0x00123, Data_in = 0xBEEF during ACCESS.
  - Response: OE low for exactly 2 cycles with ADDR = 0x00123; cpu_ack pulses in cycle 3; cpu_rdata = 0xBEEF.
- Aux write:
  - Stimulus: aux_addr = 0x0FFFF, aux_wdata = 0x1234.
  - Response: WE low 2 cycles; Data_oe = 1 for those cycles plus the DONE cycle; Data_out = 0x1234; aux_ack pulses once; OE stays high.
- Simultaneous requests, macro undefined, both held high for 4 accesses: grants are CPU, CPU, CPU, CPU; aux is never acked.
- Simultaneous requests, macro defined: grants are CPU, aux, CPU, aux; owner toggles; each ack arrives 4 cycles apart.
- Reset mid-access: Reset low in the second ACCESS cycle of a write. WE, CE and Data_oe deassert in the same cycle; no ack appears; after release the next cpu_req completes normally.
- Early req drop: cpu_req dropped and cpu_addr changed in the first ACCESS cycle. The access completes to the original address and cpu_ack still pulses.
